nand_cmd_addr_seq: RTL and testbench
====================================

// Module: nand_cmd_addr_seq
// PURPOSE
//  Parametrised NAND flash command/address latch sequencer. On a start request it latches a
//  command byte, ADDR_CYC address bytes and an optional second command, and drives them onto
//  the NAND IO bus with CLE/ALE/CE_n/WE_n timing generated from clk-cycle counters.
//  Sits between the flash controller FSM and the NAND pad ring. Data-phase logic is separate.
// PARAMETERS
//  IO_W      8   NAND IO bus width (bits per bus cycle)
//  ADDR_W    32  width of addr input
//  ADDR_CYC  4   address bus cycles per operation, legal 1..8
//  T_WP      2   clk cycles WE_n held low per bus cycle, >=1
//  T_WH      2   clk cycles WE_n held high per bus cycle, >=1
// PORTS
//  clk       in   1        system clock, all logic on rising edge
//  rst       in   1        asynchronous reset, active-low
//  start     in   1        request; accepted on rising edge when busy==0
//  cmd1      in   IO_W     first command byte, CLE cycle
//  cmd2      in   IO_W     second command byte, CLE cycle after address
//  use_cmd2  in   1        1: issue cmd2 after address; 0: skip it
//  addr      in   ADDR_W   address, sent LSB byte first
//  busy      out  1        operation in progress
//  done      out  1        one-cycle pulse when the sequence completes
//  ce_n      out  1        NAND chip enable, active-low
//  cle       out  1        command latch enable
//  ale       out  1        address latch enable
//  we_n      out  1        write enable, active-low; NAND latches on the rising edge
//  io_out    out  IO_W     IO bus drive value
//  io_oe     out  1        IO bus output enable
// BEHAVIOUR
//  - Reset (rst=0, async): ce_n=1, we_n=1, cle=0, ale=0, io_out=0, io_oe=0, busy=0, done=0,
//    state=IDLE, counters=0. Reset mid-operation aborts at once; no partial sequence resumes.
//  - All outputs are registered. States: IDLE, SETUP, CMD1, ADDR, CMD2, DONE.
//  - Accept edge E0 (start=1, busy=0): latch cmd1/cmd2/use_cmd2/addr, go to SETUP:
//    busy=1, ce_n=0, io_oe=1, we_n=1. SETUP lasts one cycle (CE/CLE setup time).
//  - Bus cycle = T_WP cycles we_n=0, then T_WH cycles we_n=1. cle, ale and io_out stay stable
//    for the whole bus cycle. The next bus cycle starts on the edge after the last high cycle.
//  - CMD1: cle=1, ale=0, io_out=cmd1. ADDR: cle=0, ale=1, io_out=byte i, i=0..ADDR_CYC-1,
//    byte i = addr[IO_W*i +: IO_W]. Bits beyond ADDR_W read as 0.
//    CMD2 (use_cmd2=1 only): cle=1, ale=0, io_out=cmd2.
//  - N = 1 + ADDR_CYC + use_cmd2 bus cycles. DONE is entered at edge E0+1+N*(T_WP+T_WH).
//    In DONE: done=1, busy=0, ce_n=1, cle=0, ale=0, io_oe=0, we_n=1, io_out=0.
//  - DONE lasts one cycle, then IDLE (done=0). A start during DONE is accepted, giving
//    back-to-back operations with ce_n high for exactly 1 cycle.
//  - start while busy=1 is ignored. Latched inputs are not affected by input changes mid-op.
//  - Phase counter width $clog2(T_WP+T_WH+1). Byte index width $clog2(ADDR_CYC+1).
//    Both counters clear at each bus-cycle and state boundary.
// STRUCTURE
//  - Package nand_pkg: state enum encoding; NAND command constants (CMD_READ1 8'h00,
//    CMD_READ2 8'h30, CMD_PROG1 8'h80, CMD_PROG2 8'h10, CMD_ERASE1 8'h60,
//    CMD_ERASE2 8'hD0, CMD_RESET 8'hFF); default T_WP/T_WH.
//  - Sub-module nand_we_timer (params T_WP, T_WH):
//    - inputs clk, rst, go; outputs we_n and cyc_end (pulses on the last high cycle).
//    - Top-level FSM advances state and byte index on cyc_end.
// TESTING
//  1. Defaults, cmd1=8'h00, addr=32'h1234_5678, cmd2=8'h30, use_cmd2=1 -> io_out
//     sequence 00,78,56,34,12,30. cle=1 on bus cycles 1 and 6, ale=1 on cycles 2-5.
//     done pulses at E0+25, with 6 we_n rising edges.
//  2. Same with use_cmd2=0 -> 5 bus cycles, no CLE after address, done at E0+21.
//  3. start re-pulsed mid-ADDR with different addr -> ignored; original bytes complete.
//     Exactly one done pulse.
//  4. rst low during address byte 2 -> outputs take reset values in the same cycle.
//     After release, a new start runs the full sequence from CMD1.
//  5. ADDR_CYC=5, ADDR_W=32, addr=32'hAABBCCDD -> address bytes DD,CC,BB,AA,00.
//  6. T_WP=1, T_WH=1, start held high through DONE -> second op accepted in the DONE cycle.
//     ce_n high for exactly 1 cycle between ops, each bus cycle 2 clks long.

Source files
------------

// File: rtl/nand_pkg.sv
// Shared types and constants for the NAND command/address sequencer.
// State encoding, standard NAND opcodes and default WE_n timing.
package nand_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CMD1  = 3'd2,
    ST_ADDR  = 3'd3,
    ST_CMD2  = 3'd4,
    ST_DONE  = 3'd5
  } nand_state_e;

  localparam logic [7:0] CMD_READ1  = 8'h00;
  localparam logic [7:0] CMD_READ2  = 8'h30;
  localparam logic [7:0] CMD_PROG1  = 8'h80;
  localparam logic [7:0] CMD_PROG2  = 8'h10;
  localparam logic [7:0] CMD_ERASE1 = 8'h60;
  localparam logic [7:0] CMD_ERASE2 = 8'hD0;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  localparam int T_WP_DEF = 2;
  localparam int T_WH_DEF = 2;

  // States that drive a WE_n-strobed bus cycle.
  function automatic logic is_bus_state(input nand_state_e s);
    case (s)
      ST_CMD1, ST_ADDR, ST_CMD2: is_bus_state = 1'b1;
      default:                   is_bus_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nand_we_timer.sv
// WE_n strobe generator: while go_i is high, repeats T_WP low / T_WH high cycles
// and flags the final high cycle of each bus cycle on cyc_end_o.
module nand_we_timer #(
  parameter int T_WP = 2,
  parameter int T_WH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic go_i,
  output logic we_n_o,
  output logic cyc_end_o
);

  localparam int PER  = T_WP + T_WH;
  localparam int PH_W = $clog2(PER + 1);

  logic [PH_W-1:0] phase_q, phase_d;
  logic            active_q, active_d;
  logic            we_n_q, we_n_d;
  logic            cyc_end_q, cyc_end_d;

  // Next phase; go_i reflects the state about to be entered, so outputs land registered.
  always_comb begin
    phase_d   = '0;
    active_d  = 1'b0;
    we_n_d    = 1'b1;
    cyc_end_d = 1'b0;
    if (go_i) begin
      active_d = 1'b1;
      if (!active_q || (phase_q == PH_W'(PER - 1))) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
      we_n_d    = (phase_d >= PH_W'(T_WP));
      cyc_end_d = (phase_d == PH_W'(PER - 1));
    end else begin
      phase_d   = '0;
      active_d  = 1'b0;
      we_n_d    = 1'b1;
      cyc_end_d = 1'b0;
    end
  end

  // Phase counter and strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q   <= '0;
      active_q  <= 1'b0;
      we_n_q    <= 1'b1;
      cyc_end_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      active_q  <= active_d;
      we_n_q    <= we_n_d;
      cyc_end_q <= cyc_end_d;
    end
  end

  assign we_n_o    = we_n_q;
  assign cyc_end_o = cyc_end_q;

endmodule

// File: rtl/nand_cmd_addr_seq.sv
// NAND command/address latch sequencer: CMD1, ADDR_CYC address bytes (LSB first)
// and an optional CMD2, with registered CLE/ALE/CE_n/WE_n/IO outputs.
module nand_cmd_addr_seq
  import nand_pkg::*;
#(
  parameter int IO_W     = 8,
  parameter int ADDR_W   = 32,
  parameter int ADDR_CYC = 4,
  parameter int T_WP     = T_WP_DEF,
  parameter int T_WH     = T_WH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [IO_W-1:0]   cmd1_i,
  input  logic [IO_W-1:0]   cmd2_i,
  input  logic              use_cmd2_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              ce_n_o,
  output logic              cle_o,
  output logic              ale_o,
  output logic              we_n_o,
  output logic [IO_W-1:0]   io_out_o,
  output logic              io_oe_o
);

  localparam int IDX_W = $clog2(ADDR_CYC + 1);
  localparam int PAD_W = IO_W * ADDR_CYC;

  nand_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IO_W-1:0]   cmd1_q, cmd1_d, cmd2_q, cmd2_d;
  logic              use_cmd2_q, use_cmd2_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              busy_q, busy_d, done_q, done_d, ce_n_q, ce_n_d;
  logic              cle_q, cle_d, ale_q, ale_d, io_oe_q, io_oe_d;
  logic [IO_W-1:0]   io_out_q, io_out_d;

  logic              accept_s, cyc_end_s, go_s;
  logic [PAD_W-1:0]  addr_ext_s;
  logic [IO_W-1:0]   addr_byte_s;

  // Sequencing: start is only honoured from IDLE or DONE; operands are frozen at accept.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    accept_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept_s = 1'b1;
          state_d  = ST_SETUP;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_CMD1;
        idx_d   = '0;
      end
      ST_CMD1: begin
        if (cyc_end_s) begin
          state_d = ST_ADDR;
          idx_d   = '0;
        end else begin
          state_d = ST_CMD1;
        end
      end
      ST_ADDR: begin
        if (cyc_end_s) begin
          if (idx_q == IDX_W'(ADDR_CYC - 1)) begin
            idx_d   = '0;
            state_d = use_cmd2_q ? ST_CMD2 : ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_CMD2: begin
        if (cyc_end_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CMD2;
        end
      end
      ST_DONE: begin
        idx_d = '0;
        if (start_i) begin
          accept_s = 1'b1;
          state_d  = ST_SETUP;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
    if (accept_s) begin
      cmd1_d     = cmd1_i;
      cmd2_d     = cmd2_i;
      use_cmd2_d = use_cmd2_i;
      addr_d     = addr_i;
    end else begin
      cmd1_d     = cmd1_q;
      cmd2_d     = cmd2_q;
      use_cmd2_d = use_cmd2_q;
      addr_d     = addr_q;
    end
  end

  assign go_s        = is_bus_state(state_d);
  assign addr_ext_s  = PAD_W'(addr_d);
  assign addr_byte_s = IO_W'(addr_ext_s >> (IO_W * int'(idx_d)));

  // Pin values for the state being entered; SETUP pre-drives CLE and CMD1 ahead of WE_n.
  always_comb begin
    busy_d   = 1'b0;
    done_d   = 1'b0;
    ce_n_d   = 1'b1;
    cle_d    = 1'b0;
    ale_d    = 1'b0;
    io_oe_d  = 1'b0;
    io_out_d = '0;
    case (state_d)
      ST_SETUP, ST_CMD1: begin
        busy_d   = 1'b1;
        ce_n_d   = 1'b0;
        io_oe_d  = 1'b1;
        cle_d    = 1'b1;
        io_out_d = cmd1_d;
      end
      ST_ADDR: begin
        busy_d   = 1'b1;
        ce_n_d   = 1'b0;
        io_oe_d  = 1'b1;
        ale_d    = 1'b1;
        io_out_d = addr_byte_s;
      end
      ST_CMD2: begin
        busy_d   = 1'b1;
        ce_n_d   = 1'b0;
        io_oe_d  = 1'b1;
        cle_d    = 1'b1;
        io_out_d = cmd2_d;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      ST_IDLE: begin
        done_d = 1'b0;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // State, operand and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cmd1_q     <= '0;
      cmd2_q     <= '0;
      use_cmd2_q <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ce_n_q     <= 1'b1;
      cle_q      <= 1'b0;
      ale_q      <= 1'b0;
      io_oe_q    <= 1'b0;
      io_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cmd1_q     <= cmd1_d;
      cmd2_q     <= cmd2_d;
      use_cmd2_q <= use_cmd2_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ce_n_q     <= ce_n_d;
      cle_q      <= cle_d;
      ale_q      <= ale_d;
      io_oe_q    <= io_oe_d;
      io_out_q   <= io_out_d;
    end
  end

  nand_we_timer #(
    .T_WP(T_WP),
    .T_WH(T_WH)
  ) u_we_timer (
    .clk      (clk),
    .rst      (rst),
    .go_i     (go_s),
    .we_n_o   (we_n_o),
    .cyc_end_o(cyc_end_s)
  );

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign ce_n_o   = ce_n_q;
  assign cle_o    = cle_q;
  assign ale_o    = ale_q;
  assign io_oe_o  = io_oe_q;
  assign io_out_o = io_out_q;

endmodule

// File: tb/tb_nand_cmd_addr_seq.sv
// Scoreboard bench for nand_cmd_addr_seq: two configurations (default, and
// ADDR_CYC=5 with 1/1 WE_n timing) each with its own reference model and monitor.
module tb_nand_cmd_addr_seq;

  typedef struct packed {
    logic       cle;
    logic       ale;
    logic [7:0] io;
  } bus_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   fin [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bus_t mk(input logic c, input logic a, input logic [7:0] d);
    bus_t b;
    b.cle = c;
    b.ale = a;
    b.io  = d;
    return b;
  endfunction

  task automatic chk(input bit ok, input string nm, input int g, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s cfg%0d actual=%0h required=%0h (cycle %0d)", nm, g, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_cfg
    localparam int AC = (g == 0) ? 4 : 5;
    localparam int WP = (g == 0) ? 2 : 1;
    localparam int WH = (g == 0) ? 2 : 1;
    localparam int P  = WP + WH;

    logic        rst_s = 1'b0, start_s = 1'b0, use_s = 1'b0;
    logic [7:0]  cmd1_s = 8'h00, cmd2_s = 8'h00;
    logic [31:0] addr_s = 32'h0;
    logic        busy, done, ce_n, cle, ale, we_n, io_oe;
    logic [7:0]  io_out;

    bus_t bus_q[$];
    int   done_q[$];
    int   setup_q[$];
    int   last_done = -100;
    int   last_e = 0;

    nand_cmd_addr_seq #(
      .IO_W(8), .ADDR_W(32), .ADDR_CYC(AC), .T_WP(WP), .T_WH(WH)
    ) u_dut (
      .clk(clk), .rst(rst_s), .start_i(start_s), .cmd1_i(cmd1_s), .cmd2_i(cmd2_s),
      .use_cmd2_i(use_s), .addr_i(addr_s), .busy_o(busy), .done_o(done), .ce_n_o(ce_n),
      .cle_o(cle), .ale_o(ale), .we_n_o(we_n), .io_out_o(io_out), .io_oe_o(io_oe)
    );

    // Drive one cycle; the model accepts only when no operation is outstanding.
    task automatic step(input bit st, input logic [7:0] c1, input logic [7:0] c2,
                        input bit u, input logic [31:0] a);
      logic [63:0] wide;
      int e, n;
      @(negedge clk);
      start_s = st; cmd1_s = c1; cmd2_s = c2; use_s = u; addr_s = a;
      if (st && cyc >= last_done) begin
        e = cyc + 1;
        n = 1 + AC + (u ? 1 : 0);
        wide = {32'h0, a};
        setup_q.push_back(e);
        bus_q.push_back(mk(1'b1, 1'b0, c1));
        for (int i = 0; i < AC; i++) bus_q.push_back(mk(1'b0, 1'b1, 8'((wide >> (8 * i)) & 64'hFF)));
        if (u) bus_q.push_back(mk(1'b1, 1'b0, c2));
        last_e = e;
        last_done = e + 1 + n * P;
        done_q.push_back(last_done);
      end
    endtask

    task automatic wait_idle();
      while (cyc < last_done + 1) step(1'b0, 8'h00, 8'h00, 1'b0, 32'h0);
    endtask

    // Stimulus.
    initial begin
      @(negedge clk);
      chk({ce_n, we_n, cle, ale, io_oe, busy, done, io_out} == {7'b1100000, 8'h00},
          "reset_state", g, {ce_n, we_n, cle, ale, io_oe, busy, done, io_out}, {7'b1100000, 8'h00});
      rst_s = 1'b1;
      step(1'b1, 8'h00, 8'h30, 1'b1, 32'h1234_5678);
      wait_idle();
      step(1'b1, 8'h00, 8'h30, 1'b0, 32'h1234_5678);
      wait_idle();
      step(1'b1, 8'h80, 8'h10, 1'b1, 32'hAABB_CCDD);
      wait_idle();
      repeat (400) step($urandom_range(0, 2) == 0, 8'($urandom), 8'($urandom), 1'($urandom), $urandom);
      wait_idle();
      repeat (3 * (2 + (AC + 2) * P)) step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), $urandom);
      wait_idle();
      // Abort during the second address byte.
      step(1'b1, 8'h60, 8'hD0, 1'b1, 32'h1234_5678);
      while (cyc < last_e + 2 * P + 2) step(1'b0, 8'h00, 8'h00, 1'b0, 32'h0);
      #2 rst_s = 1'b0;
      #1 chk({ce_n, we_n, cle, ale, io_oe, busy, done, io_out} == {7'b1100000, 8'h00},
             "abort_reset", g, {ce_n, we_n, cle, ale, io_oe, busy, done, io_out}, {7'b1100000, 8'h00});
      bus_q.delete(); done_q.delete(); setup_q.delete();
      last_done = -100;
      @(negedge clk);
      rst_s = 1'b1;
      step(1'b1, 8'h00, 8'h30, 1'b1, 32'h1234_5678);
      wait_idle();
      repeat (3) step(1'b0, 8'h00, 8'h00, 1'b0, 32'h0);
      chk(bus_q.size() == 0, "bus_left", g, bus_q.size(), 0);
      chk(done_q.size() == 0, "done_left", g, done_q.size(), 0);
      chk(setup_q.size() == 0, "setup_left", g, setup_q.size(), 0);
      fin[g] = 1'b1;
    end

    // Monitor: compares DUT pins against the queued expectations.
    initial begin
      bit   prev_we = 1'b1, in_bus = 1'b0;
      int   lo = 0, hi = 0;
      bus_t exp_b;
      forever begin
        @(negedge clk);
        if (!rst_s) begin
          prev_we = 1'b1; in_bus = 1'b0; lo = 0; hi = 0;
          continue;
        end
        if (setup_q.size() > 0 && cyc == setup_q[0]) begin
          void'(setup_q.pop_front());
          chk({busy, ce_n, io_oe, we_n, ale} == 5'b10110, "setup_pins", g,
              {busy, ce_n, io_oe, we_n, ale}, 5'b10110);
        end
        if (done) begin
          if (done_q.size() == 0) begin
            chk(1'b0, "done_unexpected", g, cyc, -1);
          end else begin
            chk(cyc == done_q[0], "done_cycle", g, cyc, done_q[0]);
            void'(done_q.pop_front());
          end
          chk({ce_n, we_n, cle, ale, io_oe, busy, io_out} == {6'b110000, 8'h00}, "done_pins", g,
              {ce_n, we_n, cle, ale, io_oe, busy, io_out}, {6'b110000, 8'h00});
          if (in_bus) chk(hi == WH, "we_high_len", g, hi, WH);
          in_bus = 1'b0; hi = 0;
        end
        if (done_q.size() > 0 && cyc > done_q[0]) begin
          chk(1'b0, "done_missing", g, cyc, done_q[0]);
          void'(done_q.pop_front());
        end
        if (!we_n) begin
          if (prev_we) begin
            if (in_bus) chk(hi == WH, "we_high_len", g, hi, WH);
            in_bus = 1'b1; lo = 0; hi = 0;
          end
          lo++;
        end else begin
          if (!prev_we) begin
            chk(lo == WP, "we_low_len", g, lo, WP);
            if (bus_q.size() == 0) begin
              chk(1'b0, "bus_unexpected", g, {cle, ale, io_out}, 0);
            end else begin
              exp_b = bus_q.pop_front();
              chk({cle, ale, io_out} == exp_b, "bus_cycle", g, {cle, ale, io_out}, exp_b);
            end
            chk({ce_n, io_oe, busy} == 3'b011, "bus_ctrl", g, {ce_n, io_oe, busy}, 3'b011);
            hi = 0;
          end
          if (in_bus) hi++;
        end
        prev_we = we_n;
      end
    end
  end

  initial begin
    for (int i = 0; i < 60000 && !(fin[0] && fin[1]); i++) @(negedge clk);
    chk(fin[0] && fin[1], "timeout", 0, {fin[0], fin[1]}, 2'b11);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
